// File: rtl/bb_seq_controller.sv
// Sequenced BitBlaster controller: T0..T3 timestep FSM, instruction register,
// valid/ready fetch, stall, illegal-opcode flagging and retired-instruction count.
module bb_seq_controller #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned RA_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              stall,
  output logic              inst_ready,
  output logic [DATA_W-1:0] imm,
  output logic              imm_oe,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enr,
  output logic              enw,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic [3:0]        alu_cont,
  output logic              ext,
  output logic              irin,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned IMM_W = DATA_W - 2 - RA_W;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_T1   = 2'b01;
  localparam logic [1:0] S_T2   = 2'b10;
  localparam logic [1:0] S_T3   = 2'b11;

  localparam logic [1:0] CLS_REG  = 2'b00;
  localparam logic [1:0] CLS_ADDI = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]      cls;
  logic [RA_W-1:0] rx, ry;
  logic [3:0]      func;
  logic [IMM_W-1:0] imm_fld;

  assign cls     = ir_q[DATA_W-1 -: 2];
  assign rx      = ir_q[DATA_W-3 -: RA_W];
  assign ry      = ir_q[DATA_W-3-RA_W -: RA_W];
  assign func    = ir_q[3:0];
  assign imm_fld = ir_q[IMM_W-1:0];

  assign busy        = (state_q != S_IDLE);
  assign retired_cnt = cnt_q;

  // Next state and strobes; a stall in T1..T3 leaves every strobe at its default.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    inst_ready = 1'b0;
    imm        = '0;
    imm_oe     = 1'b0;
    rin        = '0;
    rout       = '0;
    enr        = 1'b0;
    enw        = 1'b0;
    ain        = 1'b0;
    gin        = 1'b0;
    gout       = 1'b0;
    alu_cont   = 4'b0000;
    ext        = 1'b0;
    irin       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        inst_ready = !stall;
        if (inst_valid && !stall) begin
          ext     = 1'b1;
          irin    = 1'b1;
          ir_d    = inst_in;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (!stall) begin
          if (cls == CLS_REG && func == 4'b0000) begin
            ext     = 1'b1;
            rin     = rx;
            enr     = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end else if (cls == CLS_REG && func == 4'b0001) begin
            rout    = ry;
            enw     = 1'b1;
            rin     = rx;
            enr     = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end else if ((cls == CLS_REG && func <= 4'b1011) || cls[1]) begin
            rout    = rx;
            enw     = 1'b1;
            ain     = 1'b1;
            state_d = S_T2;
          end else begin
            illegal = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_T2: begin
        if (!stall) begin
          gin = 1'b1;
          if (cls == CLS_REG) begin
            rout     = ry;
            enw      = 1'b1;
            alu_cont = func;
          end else begin
            imm      = {{(DATA_W-IMM_W){1'b0}}, imm_fld};
            imm_oe   = 1'b1;
            alu_cont = (cls == CLS_ADDI) ? 4'b0010 : 4'b0011;
          end
          state_d = S_T3;
        end
      end
      default: begin
        if (!stall) begin
          gout    = 1'b1;
          rin     = rx;
          enr     = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase

    if (done) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
